// File: rtl/regfile_ctx_dump.sv
`default_nettype none
// regfile_ctx_dump: streams x[FIRST_REG..LAST_REG] out over valid/ready, optionally zeroizing each.
// Revision 1.0
module regfile_ctx_dump #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              wipe_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              core_stall_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] rf_rs_o,
   input  logic [DATA_W-1:0] rf_data_i,
   output logic              rf_wen_o,
   output logic [ADDR_W-1:0] rf_rsW_o,
   output logic [DATA_W-1:0] rf_dataW_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [ADDR_W-1:0] m_idx_o,
   output logic [DATA_W-1:0] m_data_o
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_SEND = 3'd2,
      S_WIPE = 3'd3,
      S_DONE = 3'd4
   } state_e;

   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);
   localparam logic [ADDR_W-1:0] ONE_IDX   = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] m_idx_q, m_idx_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              wipe_q, wipe_d;
   logic              last_w;

   assign last_w = (idx_q == LAST_IDX);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         idx_q    <= FIRST_IDX;
         wipe_q   <= 1'b0;
         m_idx_q  <= '0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wipe_q   <= wipe_d;
         m_idx_q  <= m_idx_d;
         m_data_q <= m_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wipe_d    = wipe_q;
      m_idx_d   = m_idx_q;
      m_data_d  = m_data_q;
      rf_rs_o   = '0;
      rf_wen_o  = 1'b0;
      rf_rsW_o  = '0;
      m_valid_o = 1'b0;
      done_o    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               wipe_d  = wipe_i;
               idx_d   = FIRST_IDX;
               state_d = S_READ;
            end
         end
         S_READ: begin
            rf_rs_o  = idx_q;
            m_data_d = rf_data_i;
            m_idx_d  = idx_q;
            state_d  = S_SEND;
         end
         S_SEND: begin
            m_valid_o = 1'b1;
            if (m_ready_i) begin
               if (wipe_q) begin
                  state_d = S_WIPE;
               end else if (last_w) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ONE_IDX;
                  state_d = S_READ;
               end
            end
         end
         S_WIPE: begin
            // x0 is hardwired; never issue a write to it even if misparameterised
            rf_wen_o = (idx_q != '0);
            rf_rsW_o = idx_q;
            if (last_w) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ONE_IDX;
               state_d = S_READ;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides every transition, including a handshake in the same cycle
      if (abort_i) begin
         state_d = S_IDLE;
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign core_stall_o = busy_o;
   assign rf_dataW_o   = '0;
   assign m_idx_o      = m_idx_q;
   assign m_data_o     = m_data_q;

   a_reg_range: assert property (@(posedge clk_i) FIRST_REG <= LAST_REG);

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctx_dump.sv
`default_nettype none
// tb_regfile_ctx_dump: random-data/backpressure bench with a behavioural regfile and stream model.
// Revision 1.0
module tb_regfile_ctx_dump;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int FIRST = 1;
   localparam int LAST  = 31;

   logic          clk_i     = 1'b0;
   logic          rst_ni    = 1'b0;
   logic          start_i   = 1'b0;
   logic          wipe_i    = 1'b0;
   logic          abort_i   = 1'b0;
   logic          m_ready_i = 1'b0;
   logic          busy_o, core_stall_o, done_o, rf_wen_o, m_valid_o;
   logic [AW-1:0] rf_rs_o, rf_rsW_o, m_idx_o;
   logic [DW-1:0] rf_data_i, rf_dataW_o, m_data_o;

   logic [DW-1:0] rf     [32];
   logic [DW-1:0] pre_rf [32];
   logic [DW-1:0] gold   [32];
   logic          load_req = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   regfile_ctx_dump #(
      .DATA_W(DW), .ADDR_W(AW), .FIRST_REG(FIRST), .LAST_REG(LAST)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .wipe_i(wipe_i), .abort_i(abort_i),
      .busy_o(busy_o), .core_stall_o(core_stall_o), .done_o(done_o),
      .rf_rs_o(rf_rs_o), .rf_data_i(rf_data_i),
      .rf_wen_o(rf_wen_o), .rf_rsW_o(rf_rsW_o), .rf_dataW_o(rf_dataW_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_idx_o(m_idx_o), .m_data_o(m_data_o)
   );

   always #5 clk_i = ~clk_i;

   // Register file beside the block: combinational read, writes commit on the falling edge
   assign rf_data_i = (rf_rs_o == '0) ? '0 : rf[rf_rs_o];
   always @(negedge clk_i) begin
      if (load_req) rf <= pre_rf;
      else if (rf_wen_o && rf_rsW_o != '0) rf[rf_rsW_o] <= rf_dataW_o;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic zero_outs(input string tag);
      chk(tag, {busy_o, core_stall_o, done_o, rf_wen_o, m_valid_o, rf_rs_o, rf_rsW_o, m_idx_o,
                rf_dataW_o}, '0);
      chk(tag, m_data_o, '0);
   endtask

   task automatic preload(input bit seq);
      for (int k = 0; k < 32; k++) begin
         pre_rf[k] = (k == 0) ? '0 : (seq ? (32'h1000_0000 + DW'(k)) : DW'($urandom));
         gold[k]   = pre_rf[k];
      end
      load_req = 1'b1;
      @(negedge clk_i);
      #1 load_req = 1'b0;
   endtask

   // One dump request; the model tracks the next expected index and zeroes accepted regs on wipe
   task automatic run(input bit wipe, input int ready_pct, input int abort_idx, input int rst_idx,
                      input bit poke);
      int            exp_idx  = FIRST;
      int            beats    = 0;
      int            dones    = 0;
      int            done_cyc = 0;
      bit            fin      = 0;
      bit            aborted  = 0;
      bit            was_rst  = 0;
      bit            pv       = 0;
      logic [AW-1:0] pidx     = '0;
      logic [DW-1:0] pdata    = '0;
      @(posedge clk_i);
      #1 start_i = 1'b1;
      wipe_i = wipe;
      for (int n = 1; n <= 400 && !fin; n++) begin
         @(posedge clk_i);
         #1;
         start_i   = poke ? 1'($urandom_range(1)) : 1'b0;
         wipe_i    = 1'($urandom_range(1));
         abort_i   = 1'b0;
         m_ready_i = ($urandom_range(99) < ready_pct);
         if (n == 1) chk("busy_after_start", {busy_o, core_stall_o}, 2'b11);
         if (aborted) begin
            chk("abort_to_idle", busy_o, 1'b0);
            fin = 1;
         end else if (m_valid_o && int'(m_idx_o) == rst_idx) begin
            #1 rst_ni = 1'b0;
            #1 zero_outs("async_reset_outs");
            @(posedge clk_i);
            #1 rst_ni = 1'b1;
            was_rst = 1;
            fin = 1;
         end else begin
            if (m_valid_o && int'(m_idx_o) == abort_idx) begin
               abort_i   = 1'b1;
               m_ready_i = 1'b1;
            end
            @(negedge clk_i);
            chk("stall_eq_busy", core_stall_o, busy_o);
            if (!busy_o) begin
               fin = 1;
            end else begin
               if (pv) begin
                  chk("valid_held", m_valid_o, 1'b1);
                  if (m_valid_o) chk("held_stable", {m_idx_o, m_data_o}, {pidx, pdata});
               end
               pv = 0;
               if (m_valid_o) begin
                  chk("beat_idx", m_idx_o, exp_idx);
                  chk("beat_data", m_data_o, gold[exp_idx]);
                  pv = !m_ready_i;
                  pidx = m_idx_o;
                  pdata = m_data_o;
                  if (abort_i) begin
                     aborted = 1;
                  end else if (m_ready_i) begin
                     beats++;
                     if (wipe) gold[exp_idx] = '0;
                     exp_idx++;
                  end
               end
               if (rf_wen_o) begin
                  chk("wipe_addr", rf_rsW_o, exp_idx - 1);
                  chk("wipe_zero", rf_dataW_o, '0);
               end
               if (done_o) begin
                  dones++;
                  done_cyc = n;
                  chk("done_after_last", exp_idx, LAST + 1);
               end
               if (!m_valid_o && !rf_wen_o && !done_o) chk("read_addr", rf_rs_o, exp_idx);
               else chk("read_addr_idle", rf_rs_o, '0);
            end
         end
      end
      start_i   = 1'b0;
      abort_i   = 1'b0;
      m_ready_i = 1'b0;
      if (!fin) chk("timeout", 1'b0, 1'b1);
      if (aborted) begin
         chk("abort_no_done", dones, 0);
      end else if (!was_rst) begin
         chk("beat_count", beats, LAST - FIRST + 1);
         chk("done_count", dones, 1);
         if (ready_pct == 100) chk("done_cycle", done_cyc, (LAST - FIRST + 1) * (wipe ? 3 : 2) + 1);
      end
      for (int k = 0; k < 32; k++) chk("rf_contents", rf[k], gold[k]);
   endtask

   initial begin
      #12 zero_outs("reset_outs");
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      preload(1'b1); run(1'b0, 100, 0, 0, 1'b0);   // plain dump, sink always ready
      preload(1'b1); run(1'b1, 100, 0, 0, 1'b0);   // dump with wipe
      preload(1'b0); run(1'b0, 50, 0, 0, 1'b0);    // backpressure
      preload(1'b0); run(1'b1, 50, 0, 0, 1'b0);    // backpressure with wipe
      preload(1'b0); run(1'b1, 60, 7, 0, 1'b0);    // abort on the x7 handshake
      preload(1'b0); run(1'b1, 70, 0, 12, 1'b0);   // reset while x12 is on the stream
      preload(1'b0); run(1'b0, 100, 0, 0, 1'b1);   // start_i poked while busy

      // abort and start together in IDLE: abort wins
      @(posedge clk_i);
      #1 start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      abort_i = 1'b0;
      chk("abort_beats_start", busy_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #1 chk("still_idle", {busy_o, m_valid_o, rf_rs_o}, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
